fa: RTL and testbench
=====================

# fa

Registered full adder: adds operands `a`, `b` and carry-in `cin`, and presents sum `s` and carry-out `co` on registered outputs one clock after sampling. It is the basic arithmetic cell of the datapath. The default configuration is the classic 1-bit full adder; a width parameter lets the same block serve as a registered ripple-carry adder.

## Interface
- `WIDTH`, default 1: operand width in bits; legal range 1..64.
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `a`  input  WIDTH: addend.
- `b`  input  WIDTH: addend.
- `cin`  input  1: carry-in into bit 0.
- `co`  output  1: registered carry-out of the MSB.
- `s`  output  WIDTH: registered sum.
- Port order: `clk, rst, a, b, cin, co, s`.

## Operation
- Per bit i: `s[i] = a[i] ^ b[i] ^ c[i]`; `c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]`; `c[0] = cin`; `co = c[WIDTH]`.
- This is equivalent to `{co, s} = a + b + cin`, computed at WIDTH+1 bits, with no overflow loss.
- The sum is unsigned. Signed overflow is not reported.
- For WIDTH=1, the truth table over `{a,b,cin}`:
  - 000 -> co=0, s=0
  - 001, 010, 100 -> co=0, s=1
  - 011, 101, 110 -> co=1, s=0
  - 111 -> co=1, s=1
- There is no enable and no handshake. A new result is produced every cycle.
- X/Z on inputs is not filtered. Outputs follow the inputs with the same propagation semantics.

## Timing
- Inputs are sampled on the rising edge of `clk`. `co`/`s` reflect that sample after the edge, giving a latency of exactly 1 cycle and a throughput of 1 result per cycle.
- Reset value: `co=0`, `s=0`. The outputs clear immediately when `rst` rises, with no clock needed.
- While `rst` is high, the outputs are held at 0 and input changes are ignored.
- On the first rising edge after `rst` falls, the outputs load the then-current inputs.
- Reset asserted mid-stream discards the in-flight result. No stale value reappears after release.
- Inputs changing between edges have no effect on outputs until the next edge. The outputs are glitch-free.
- The carry chain is fully combinational within one cycle. For large WIDTH, timing closure is the integrator's responsibility; no internal pipelining.

## Structure
- No shared package needed. The block has no typedefs or enums, and WIDTH is the only constant.
- One natural sub-module: `fa_cell`, a combinational 1-bit full adder with ports `a, b, cin, co, s`.
- `fa` instantiates WIDTH copies of `fa_cell` in a generate loop, chaining each `co` to the next `cin`.
- `fa` holds a single output register of WIDTH+1 bits with async reset.

## Test plan
- Exhaustive truth table, WIDTH=1: apply `{a,b,cin}` 000..111, one per cycle, repeated 3 times. Each cycle later, `{co,s}` must read 00,01,01,10,01,10,10,11.
- Reset value: assert `rst` with `a=1,b=1,cin=1`. Without any clock edge, `co=0,s=0`, and they stay 0 while `rst` is high across several edges.
- Reset mid-stream: apply `111`, then assert `rst` between edges. Outputs drop to 00 at once. After release with inputs at `011`, the first edge gives co=1, s=0.
- Latency/hold, WIDTH=1: change inputs between clock edges from `000` to `110`. Outputs stay 00 until the next rising edge, then become co=1, s=0.
- Carry propagation, WIDTH=4:
  - a=4'hF, b=4'h0, cin=1 -> s=4'h0, co=1 one cycle later.
  - a=4'h7, b=4'h8, cin=0 -> s=4'hF, co=0.
- Random, WIDTH=8: 1000 random `a,b,cin` vectors. Each `{co,s}` must equal `a+b+cin` from the previous cycle.

Source files
------------

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder, one link of the ripple chain.
//
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   co    - carry out (majority of a, b, cin)
//   s     - sum bit (odd parity of a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa.sv
// fa: registered ripple-carry adder. Computes {co, s} = a + b + cin at
// WIDTH+1 bits and presents the result on registered outputs one clock after
// the inputs are sampled. WIDTH=1 gives the classic registered full adder.
//
// Parameters:
//   WIDTH - operand width in bits, 1..64
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; clears co/s immediately
//   a   - addend, WIDTH bits
//   b   - addend, WIDTH bits
//   cin - carry into bit 0
//   co  - registered carry out of the MSB
//   s   - registered sum, WIDTH bits
module fa #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             co,
  output logic [WIDTH-1:0] s
);

  // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   res_d;
  logic [WIDTH:0]   res_q;

  assign c[0] = cin;

  // Carry chain is purely combinational across all bits; no internal
  // pipelining, so long widths put the whole ripple path in one cycle.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .co  (c[i+1]),
      .s   (sum_bits[i])
    );
  end

  assign res_d = {c[WIDTH], sum_bits};

  // Output register: the only state in the block. Async reset discards any
  // in-flight result so nothing stale appears after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign co = res_q[WIDTH];
  assign s  = res_q[WIDTH-1:0];

endmodule

// File: tb/tb_fa.sv
module tb_fa;

  logic clk;
  logic rst;

  logic       a1, b1, cin1, co1, s1;
  logic [3:0] a4, b4, s4;
  logic       cin4, co4;
  logic [7:0] a8, b8, s8;
  logic       cin8, co8;

  int n_tests;
  int n_fail;

  fa #(.WIDTH(1)) u_fa1 (
    .clk (clk), .rst (rst), .a (a1), .b (b1), .cin (cin1), .co (co1), .s (s1)
  );

  fa #(.WIDTH(4)) u_fa4 (
    .clk (clk), .rst (rst), .a (a4), .b (b4), .cin (cin4), .co (co4), .s (s4)
  );

  fa #(.WIDTH(8)) u_fa8 (
    .clk (clk), .rst (rst), .a (a8), .b (b8), .cin (cin8), .co (co8), .s (s8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {co,s} of a full adder is the 2-bit count of ones among inputs.
  function automatic logic [1:0] ref1(input logic [2:0] v);
    return 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
  endfunction

  initial begin
    logic [1:0] tt_exp [8];
    logic [8:0] exp8;
    logic [4:0] exp4;

    n_tests = 0;
    n_fail  = 0;
    tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    rst = 1'b1;
    {a1, b1, cin1} = 3'b000;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_rst_w1", {co1, s1}, 2'b00);
    chk("init_rst_w8", {co8, s8}, 9'h000);
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive truth table, three passes.
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 8; v++) begin
        @(negedge clk);
        {a1, b1, cin1} = 3'(v);
        @(posedge clk);
        #1;
        chk($sformatf("tt_r%0d_v%0d", r, v), {co1, s1}, tt_exp[v]);
        chk($sformatf("tt_ref_r%0d_v%0d", r, v), {co1, s1}, ref1(3'(v)));
      end
    end

    // Latency / hold: input change between edges must not reach outputs.
    @(negedge clk);
    {a1, b1, cin1} = 3'b000;
    @(posedge clk);
    #1;
    chk("hold_pre", {co1, s1}, 2'b00);
    #2;
    {a1, b1, cin1} = 3'b110;
    #1;
    chk("hold_mid", {co1, s1}, 2'b00);
    @(posedge clk);
    #1;
    chk("hold_post", {co1, s1}, 2'b10);

    // Reset value and mid-stream reset.
    @(negedge clk);
    {a1, b1, cin1} = 3'b111;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_w1", {co1, s1}, 2'b11);
    chk("pre_rst_w8", {co8, s8}, 9'h101);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_w1", {co1, s1}, 2'b00);
    chk("rst_async_w8", {co8, s8}, 9'h000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      {a1, b1, cin1} = 3'b111;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold_w1_%0d", k), {co1, s1}, 2'b00);
      chk($sformatf("rst_hold_w8_%0d", k), {co8, s8}, 9'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    {a1, b1, cin1} = 3'b011;
    @(posedge clk);
    #1;
    chk("rst_release", {co1, s1}, 2'b10);

    // Carry propagation, WIDTH=4.
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    @(posedge clk);
    #1;
    chk("w4_ripple_s", s4, 4'h0);
    chk("w4_ripple_co", co4, 1'b1);
    @(negedge clk);
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0;
    @(posedge clk);
    #1;
    chk("w4_nocarry_s", s4, 4'hF);
    chk("w4_nocarry_co", co4, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      exp4 = 5'(a4) + 5'(b4) + 5'(cin4);
      @(posedge clk);
      #1;
      chk($sformatf("w4_rand_%0d", k), {co4, s4}, exp4);
    end

    // Random, WIDTH=8.
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      exp8 = 9'(a8) + 9'(b8) + 9'(cin8);
      @(posedge clk);
      #1;
      chk($sformatf("w8_rand_%0d", k), {co8, s8}, exp8);
    end

    // Boundary: all-ones plus carry-in on WIDTH=8.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(posedge clk);
    #1;
    chk("w8_max", {co8, s8}, 9'h1FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
